// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm controller: state encoding, digit width,
// parameter defaults and a BCD packing helper.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam int DIG_W          = 4;
    localparam int HHMM_W         = 4 * DIG_W;
    localparam int RING_SEC_DEF   = 60;
    localparam int SNOOZE_SEC_DEF = 300;
    localparam int MAX_SNOOZE_DEF = 3;
    localparam int CNT_W_DEF      = 9;

    // Packs HH:MM digits into one word, hour tens in the top nibble.
    function automatic logic [HHMM_W-1:0] pack_hhmm(
        input logic [DIG_W-1:0] d3,
        input logic [DIG_W-1:0] d2,
        input logic [DIG_W-1:0] d1,
        input logic [DIG_W-1:0] d0
    );
        return {d3, d2, d1, d0};
    endfunction

endpackage

// File: rtl/alarm_ctrl_time_match.sv
// Combinational HH:MM comparator. An alarm value of 00:00 is the cleared
// register value and never matches.
module time_match
    import alarm_ctrl_pkg::*;
(
    input  logic [DIG_W-1:0] tm_dig0,
    input  logic [DIG_W-1:0] tm_dig1,
    input  logic [DIG_W-1:0] tm_dig2,
    input  logic [DIG_W-1:0] tm_dig3,
    input  logic [DIG_W-1:0] al_dig0,
    input  logic [DIG_W-1:0] al_dig1,
    input  logic [DIG_W-1:0] al_dig2,
    input  logic [DIG_W-1:0] al_dig3,
    input  logic             al_en,
    output logic             match
);

    logic [HHMM_W-1:0] tm_word;
    logic [HHMM_W-1:0] al_word;
    logic              al_loaded;

    assign tm_word   = pack_hhmm(tm_dig3, tm_dig2, tm_dig1, tm_dig0);
    assign al_word   = pack_hhmm(al_dig3, al_dig2, al_dig1, al_dig0);
    assign al_loaded = (al_word != '0);
    assign match     = al_en && al_loaded && (al_word == tm_word);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: edge-detects the alarm/time match, then runs the
// IDLE/RINGING/SNOOZE sequence with a 1 Hz beep, snooze limit and timeouts.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int RING_SEC   = RING_SEC_DEF,
    parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [DIG_W-1:0] tm_dig0,
    input  logic [DIG_W-1:0] tm_dig1,
    input  logic [DIG_W-1:0] tm_dig2,
    input  logic [DIG_W-1:0] tm_dig3,
    input  logic [DIG_W-1:0] al_dig0,
    input  logic [DIG_W-1:0] al_dig1,
    input  logic [DIG_W-1:0] al_dig2,
    input  logic [DIG_W-1:0] al_dig3,
    input  logic             al_en,
    input  logic             sec_tick,
    input  logic             stop,
    input  logic             snooze,
    output logic             ringing,
    output logic             snoozed,
    output logic             buzz,
    output logic [1:0]       snooze_cnt
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             buzz_next;
    logic [1:0]       snooze_cnt_next;

    logic match_now;
    logic match_prev;
    logic trigger;
    logic abort;
    logic snooze_ok;
    logic ring_done;
    logic snooze_done;

    time_match u_time_match (
        .tm_dig0 (tm_dig0),
        .tm_dig1 (tm_dig1),
        .tm_dig2 (tm_dig2),
        .tm_dig3 (tm_dig3),
        .al_dig0 (al_dig0),
        .al_dig1 (al_dig1),
        .al_dig2 (al_dig2),
        .al_dig3 (al_dig3),
        .al_en   (al_en),
        .match   (match_now)
    );

    // One trigger per match minute, even if the match is held all minute.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) match_prev <= 1'b0;
        else         match_prev <= match_now;
    end

    assign trigger     = match_now && !match_prev;
    assign abort       = stop || !al_en;
    assign snooze_ok   = snooze && (snooze_cnt < 2'(MAX_SNOOZE));
    assign ring_done   = sec_tick && (cnt == CNT_W'(RING_SEC - 1));
    assign snooze_done = sec_tick && (cnt == CNT_W'(SNOOZE_SEC - 1));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trigger) state_next = RINGING;
            end
            RINGING: begin
                if (abort)          state_next = IDLE;
                else if (snooze_ok) state_next = SNOOZE;
                else if (ring_done) state_next = IDLE;
            end
            SNOOZE: begin
                if (abort)            state_next = IDLE;
                else if (snooze_done) state_next = RINGING;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter, beep and snooze count follow the same priority as the state.
    always_comb begin
        cnt_next        = cnt;
        buzz_next       = buzz;
        snooze_cnt_next = snooze_cnt;
        case (state)
            IDLE: begin
                cnt_next  = '0;
                buzz_next = 1'b0;
                if (trigger) begin
                    snooze_cnt_next = 2'd0;
                    buzz_next       = 1'b1;
                end
            end
            RINGING: begin
                if (abort) begin
                    cnt_next  = '0;
                    buzz_next = 1'b0;
                end else if (snooze_ok) begin
                    cnt_next        = '0;
                    buzz_next       = 1'b0;
                    snooze_cnt_next = 2'(snooze_cnt + 2'd1);
                end else if (ring_done) begin
                    cnt_next  = '0;
                    buzz_next = 1'b0;
                end else if (sec_tick) begin
                    cnt_next  = cnt + 1'b1;
                    buzz_next = !buzz;
                end
            end
            SNOOZE: begin
                if (abort) begin
                    cnt_next  = '0;
                    buzz_next = 1'b0;
                end else if (snooze_done) begin
                    cnt_next  = '0;
                    buzz_next = 1'b1;
                end else if (sec_tick) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                cnt_next  = '0;
                buzz_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt        <= '0;
            buzz       <= 1'b0;
            snooze_cnt <= 2'd0;
            ringing    <= 1'b0;
            snoozed    <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            buzz       <= buzz_next;
            snooze_cnt <= snooze_cnt_next;
            ringing    <= (state_next == RINGING);
            snoozed    <= (state_next == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: a seconds-level alarm model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_alarm_ctrl;

    localparam int RING_SEC   = 60;
    localparam int SNOOZE_SEC = 300;
    localparam int MAX_SNOOZE = 3;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] tm_dig0 = '0, tm_dig1 = '0, tm_dig2 = '0, tm_dig3 = '0;
    logic [3:0] al_dig0 = '0, al_dig1 = '0, al_dig2 = '0, al_dig3 = '0;
    logic       al_en = 1'b0;
    logic       sec_tick = 1'b0;
    logic       stop = 1'b0;
    logic       snooze = 1'b0;
    logic       ringing, snoozed, buzz;
    logic [1:0] snooze_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    alarm_ctrl dut (
        .clk        (clk),
        .reset_     (reset_),
        .tm_dig0    (tm_dig0),
        .tm_dig1    (tm_dig1),
        .tm_dig2    (tm_dig2),
        .tm_dig3    (tm_dig3),
        .al_dig0    (al_dig0),
        .al_dig1    (al_dig1),
        .al_dig2    (al_dig2),
        .al_dig3    (al_dig3),
        .al_en      (al_en),
        .sec_tick   (sec_tick),
        .stop       (stop),
        .snooze     (snooze),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .buzz       (buzz),
        .snooze_cnt (snooze_cnt)
    );

    always #5 clk = ~clk;

    // Model: mode 0 quiet, 1 ringing, 2 snoozing; elapsed seconds in the mode.
    int m_mode = 0;
    int m_elapsed = 0;
    int m_snoozes = 0;
    bit m_prev_hit = 1'b0;

    function automatic int hhmm(input logic [3:0] d3, input logic [3:0] d2,
                                input logic [3:0] d1, input logic [3:0] d0);
        return int'(d3) * 1000 + int'(d2) * 100 + int'(d1) * 10 + int'(d0);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_);
            if (!reset_) begin
                m_mode = 0; m_elapsed = 0; m_snoozes = 0; m_prev_hit = 1'b0;
            end else begin
                int  al_v, tm_v;
                bit  hit, fresh;
                al_v  = hhmm(al_dig3, al_dig2, al_dig1, al_dig0);
                tm_v  = hhmm(tm_dig3, tm_dig2, tm_dig1, tm_dig0);
                hit   = al_en && (al_v != 0) && (al_v == tm_v);
                fresh = hit && !m_prev_hit;
                m_prev_hit = hit;
                if (m_mode == 0) begin
                    if (fresh) begin m_mode = 1; m_elapsed = 0; m_snoozes = 0; end
                end else if (stop || !al_en) begin
                    m_mode = 0; m_elapsed = 0;
                end else if (m_mode == 1) begin
                    if (snooze && m_snoozes < MAX_SNOOZE) begin
                        m_mode = 2; m_elapsed = 0; m_snoozes++;
                    end else if (sec_tick) begin
                        m_elapsed++;
                        if (m_elapsed == RING_SEC) begin m_mode = 0; m_elapsed = 0; end
                    end
                end else if (sec_tick) begin
                    m_elapsed++;
                    if (m_elapsed == SNOOZE_SEC) begin m_mode = 1; m_elapsed = 0; end
                end
            end
        end
    end

    // Beep is on during even-numbered seconds of a ringing period.
    always @(negedge clk) begin
        if (started) begin
            logic [4:0] exp_v, act_v;
            exp_v = {m_mode == 1, m_mode == 2, (m_mode == 1) && (m_elapsed % 2 == 0),
                     2'(m_snoozes)};
            act_v = {ringing, snoozed, buzz, snooze_cnt};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t ring/snz/buzz/cnt actual=%b required=%b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
        end
    endtask

    task automatic press_snooze();
        snooze = 1'b1; cyc(); snooze = 1'b0;
    endtask

    task automatic press_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic set_time(input int h1, input int h0, input int m1, input int m0);
        tm_dig3 = 4'(h1); tm_dig2 = 4'(h0); tm_dig1 = 4'(m1); tm_dig0 = 4'(m0);
    endtask

    task automatic set_alarm(input int h1, input int h0, input int m1, input int m0);
        al_dig3 = 4'(h1); al_dig2 = 4'(h0); al_dig1 = 4'(m1); al_dig0 = 4'(m0);
    endtask

    task automatic retrigger_0730();
        set_time(0, 7, 3, 1); cyc();
        set_time(0, 7, 3, 0); cyc();
    endtask

    initial begin
        hold(3);
        reset_ = 1'b1;
        started = 1'b1;
        cyc();
        check("reset_ringing", ringing, 0);
        check("reset_buzz", buzz, 0);
        check("reset_snooze_cnt", snooze_cnt, 0);

        set_alarm(0, 7, 3, 0);
        set_time(0, 7, 2, 9);
        al_en = 1'b1;
        hold(3);
        check("pre_match_quiet", ringing, 0);
        set_time(0, 7, 3, 0);
        cyc();
        check("trigger_ringing", ringing, 1);
        check("trigger_buzz", buzz, 1);
        hold(100);
        check("held_match_ringing", ringing, 1);
        ticks(59);
        check("tick59_ringing", ringing, 1);
        check("tick59_buzz", buzz, 0);
        ticks(1);
        check("timeout_ringing", ringing, 0);
        check("timeout_buzz", buzz, 0);
        hold(10);
        check("no_retrigger", ringing, 0);

        retrigger_0730();
        check("second_ring", ringing, 1);
        ticks(3);
        check("tick3_buzz", buzz, 0);
        press_snooze();
        check("snooze1_snoozed", snoozed, 1);
        check("snooze1_buzz", buzz, 0);
        check("snooze1_cnt", snooze_cnt, 1);
        ticks(299);
        check("snooze299_snoozed", snoozed, 1);
        ticks(1);
        check("rering_ringing", ringing, 1);
        check("rering_buzz", buzz, 1);
        press_snooze(); ticks(300);
        press_snooze(); ticks(300);
        check("snooze3_cnt", snooze_cnt, 3);
        check("snooze3_rering", ringing, 1);
        press_snooze();
        check("snooze4_ignored_ring", ringing, 1);
        check("snooze4_ignored_snz", snoozed, 0);
        press_stop();
        check("stop_ringing", ringing, 0);
        check("stop_holds_cnt", snooze_cnt, 3);

        retrigger_0730();
        check("new_event_cnt", snooze_cnt, 0);
        stop = 1'b1; snooze = 1'b1; cyc(); stop = 1'b0; snooze = 1'b0;
        check("stop_snooze_ring", ringing, 0);
        check("stop_snooze_snz", snoozed, 0);

        retrigger_0730();
        ticks(59);
        sec_tick = 1'b1; snooze = 1'b1; cyc(); sec_tick = 1'b0; snooze = 1'b0;
        check("timeout_vs_snooze", snoozed, 1);
        set_time(0, 8, 0, 0);
        al_en = 1'b0; cyc();
        check("al_en_drop_snz", snoozed, 0);
        check("al_en_drop_ring", ringing, 0);
        al_en = 1'b1;

        set_alarm(0, 0, 0, 0); set_time(0, 0, 0, 0); hold(5);
        check("alarm_zero_quiet", ringing, 0);
        set_alarm(1, 2, 0, 0); al_en = 1'b0;
        set_time(1, 1, 5, 9); cyc();
        set_time(1, 2, 0, 0); hold(5);
        check("disabled_quiet", ringing, 0);
        al_en = 1'b1; cyc();
        check("enable_ring", ringing, 1);

        #4 reset_ = 1'b0;
        #1;
        check("async_rst_ringing", ringing, 0);
        check("async_rst_snoozed", snoozed, 0);
        check("async_rst_buzz", buzz, 0);
        check("async_rst_cnt", snooze_cnt, 0);
        @(posedge clk); #2 reset_ = 1'b1;
        cyc();
        check("post_rst_retrigger", ringing, 1);
        check("post_rst_buzz", buzz, 1);
        hold(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
